regfile_read_decoder: RTL and testbench

Parametrised, registered read-address decoder for the register file. Converts each read port's register ID into a one-hot wordline one cycle later, holds its output under pipeline stall, and flags same-cycle write/read collisions so the datapath can bypass write data. It replaces the fixed single-port 4-to-16 combinational read decoder and sits between the decode-stage register IDs and the register array's read bitlines.

---
 rtl/regfile_read_decoder_if.sv | 27 ++
 rtl/regfile_read_decoder.sv | 100 ++++++++++
 tb/tb_regfile_read_decoder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/regfile_read_decoder_if.sv
// Read-decoder bus: decode-stage requests, write snoop and stall in; wordlines and flags out.
interface regfile_read_decoder_if #(
  parameter int ADDR_W    = 4,
  parameter int NUM_REGS  = 16,
  parameter int NUM_PORTS = 2
);
  logic                          stall;
  logic [NUM_PORTS-1:0]          rd_valid;
  logic [NUM_PORTS*ADDR_W-1:0]   rd_id;
  logic                          wr_en;
  logic [ADDR_W-1:0]             wr_id;
  logic [NUM_PORTS*NUM_REGS-1:0] wordline;
  logic [NUM_PORTS-1:0]          wl_valid;
  logic [NUM_PORTS-1:0]          bypass;
  logic [NUM_PORTS-1:0]          oob;
  logic                          oob_sticky;

  modport master (
    output stall, rd_valid, rd_id, wr_en, wr_id,
    input  wordline, wl_valid, bypass, oob, oob_sticky
  );

  modport slave (
    input  stall, rd_valid, rd_id, wr_en, wr_id,
    output wordline, wl_valid, bypass, oob, oob_sticky
  );
endinterface

// File: rtl/regfile_read_decoder.sv
// Registered multi-port register-file read decoder with zero-register masking,
// out-of-range flagging and same-cycle write bypass detection.
module regfile_read_decoder #(
  parameter int ADDR_W    = 4,
  parameter int NUM_REGS  = 16,
  parameter int NUM_PORTS = 2,
  parameter int ZERO_REG  = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  regfile_read_decoder_if.slave bus
);

  localparam int              DEC_W = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_REGS);

  // Log-depth shifter: each ID bit k conditionally shifts the token by 2**k.
  function automatic logic [DEC_W-1:0] stage_decode(input logic [ADDR_W-1:0] id);
    logic [DEC_W-1:0] acc;
    acc    = {DEC_W{1'b0}};
    acc[0] = 1'b1;
    for (int k = 0; k < ADDR_W; k++) begin
      if (id[k]) begin
        acc = acc << (32'd1 << k);
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

  logic [NUM_PORTS*NUM_REGS-1:0] next_wordline_s;
  logic [NUM_PORTS-1:0]          next_valid_s;
  logic [NUM_PORTS-1:0]          next_bypass_s;
  logic [NUM_PORTS-1:0]          next_oob_s;
  logic [ADDR_W-1:0]             port_id_s;
  logic [DEC_W-1:0]              full_dec_s;
  logic                          zero_s;

  logic [NUM_PORTS*NUM_REGS-1:0] wordline_r;
  logic [NUM_PORTS-1:0]          wl_valid_r;
  logic [NUM_PORTS-1:0]          bypass_r;
  logic [NUM_PORTS-1:0]          oob_r;
  logic                          oob_sticky_r;

  // Per-port next-state decode from the current request and write snoop.
  always_comb begin
    next_wordline_s = {(NUM_PORTS*NUM_REGS){1'b0}};
    next_valid_s    = {NUM_PORTS{1'b0}};
    next_bypass_s   = {NUM_PORTS{1'b0}};
    next_oob_s      = {NUM_PORTS{1'b0}};
    port_id_s       = {ADDR_W{1'b0}};
    full_dec_s      = {DEC_W{1'b0}};
    zero_s          = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_id_s       = bus.rd_id[p*ADDR_W +: ADDR_W];
      full_dec_s      = stage_decode(port_id_s);
      zero_s          = (ZERO_REG != 0) && (port_id_s == {ADDR_W{1'b0}});
      next_valid_s[p] = bus.rd_valid[p];
      next_oob_s[p]   = bus.rd_valid[p] && ({1'b0, port_id_s} >= LIMIT);
      if (bus.rd_valid[p] && !next_oob_s[p] && !zero_s) begin
        next_wordline_s[p*NUM_REGS +: NUM_REGS] = full_dec_s[NUM_REGS-1:0];
        next_bypass_s[p] = bus.wr_en && (bus.wr_id == port_id_s);
      end else begin
        next_wordline_s[p*NUM_REGS +: NUM_REGS] = {NUM_REGS{1'b0}};
        next_bypass_s[p] = 1'b0;
      end
    end
  end

  // Output registers: reset beats stall; stall drops the cycle's inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wordline_r   <= {(NUM_PORTS*NUM_REGS){1'b0}};
      wl_valid_r   <= {NUM_PORTS{1'b0}};
      bypass_r     <= {NUM_PORTS{1'b0}};
      oob_r        <= {NUM_PORTS{1'b0}};
      oob_sticky_r <= 1'b0;
    end else if (!bus.stall) begin
      wordline_r   <= next_wordline_s;
      wl_valid_r   <= next_valid_s;
      bypass_r     <= next_bypass_s;
      oob_r        <= next_oob_s;
      oob_sticky_r <= oob_sticky_r | (|next_oob_s);
    end else begin
      wordline_r   <= wordline_r;
      wl_valid_r   <= wl_valid_r;
      bypass_r     <= bypass_r;
      oob_r        <= oob_r;
      oob_sticky_r <= oob_sticky_r;
    end
  end

  assign bus.wordline   = wordline_r;
  assign bus.wl_valid   = wl_valid_r;
  assign bus.bypass     = bypass_r;
  assign bus.oob        = oob_r;
  assign bus.oob_sticky = oob_sticky_r;

endmodule

// File: tb/tb_regfile_read_decoder.sv
// Drives three decoder configurations (default, no zero register, 12 registers)
// with shared stimulus and compares each against an arithmetic reference model.
module tb_regfile_read_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall;
  logic [1:0] rd_valid;
  logic [7:0] rd_id;
  logic       wr_en;
  logic [3:0] wr_id;

  int n_checks = 0;
  int n_bad    = 0;

  int cfg_nr [3] = '{16, 16, 12};
  int cfg_zr [3] = '{1, 0, 1};

  logic [31:0] m_wl     [3];
  logic [1:0]  m_val    [3];
  logic [1:0]  m_byp    [3];
  logic [1:0]  m_oob    [3];
  logic        m_sticky [3];

  always #5 clk = ~clk;

  regfile_read_decoder_if #(.ADDR_W(4), .NUM_REGS(16), .NUM_PORTS(2)) if0 ();
  regfile_read_decoder_if #(.ADDR_W(4), .NUM_REGS(16), .NUM_PORTS(2)) if1 ();
  regfile_read_decoder_if #(.ADDR_W(4), .NUM_REGS(12), .NUM_PORTS(2)) if2 ();

  assign if0.stall = stall;  assign if1.stall = stall;  assign if2.stall = stall;
  assign if0.rd_valid = rd_valid; assign if1.rd_valid = rd_valid; assign if2.rd_valid = rd_valid;
  assign if0.rd_id = rd_id;  assign if1.rd_id = rd_id;  assign if2.rd_id = rd_id;
  assign if0.wr_en = wr_en;  assign if1.wr_en = wr_en;  assign if2.wr_en = wr_en;
  assign if0.wr_id = wr_id;  assign if1.wr_id = wr_id;  assign if2.wr_id = wr_id;

  regfile_read_decoder #(.ADDR_W(4), .NUM_REGS(16), .NUM_PORTS(2), .ZERO_REG(1))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  regfile_read_decoder #(.ADDR_W(4), .NUM_REGS(16), .NUM_PORTS(2), .ZERO_REG(0))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  regfile_read_decoder #(.ADDR_W(4), .NUM_REGS(12), .NUM_PORTS(2), .ZERO_REG(1))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    check_eq("c0_wl",  32'(if0.wordline), m_wl[0]);
    check_eq("c0_val", 32'(if0.wl_valid), 32'(m_val[0]));
    check_eq("c0_byp", 32'(if0.bypass),   32'(m_byp[0]));
    check_eq("c0_oob", 32'(if0.oob),      32'(m_oob[0]));
    check_eq("c0_stk", 32'(if0.oob_sticky), 32'(m_sticky[0]));
    check_eq("c1_wl",  32'(if1.wordline), m_wl[1]);
    check_eq("c1_val", 32'(if1.wl_valid), 32'(m_val[1]));
    check_eq("c1_byp", 32'(if1.bypass),   32'(m_byp[1]));
    check_eq("c1_oob", 32'(if1.oob),      32'(m_oob[1]));
    check_eq("c1_stk", 32'(if1.oob_sticky), 32'(m_sticky[1]));
    check_eq("c2_wl",  32'(if2.wordline), m_wl[2]);
    check_eq("c2_val", 32'(if2.wl_valid), 32'(m_val[2]));
    check_eq("c2_byp", 32'(if2.bypass),   32'(m_byp[2]));
    check_eq("c2_oob", 32'(if2.oob),      32'(m_oob[2]));
    check_eq("c2_stk", 32'(if2.oob_sticky), 32'(m_sticky[2]));
    check_eq("c0_1hot_p0", 32'($countones(if0.wordline[15:0])  <= 1), 32'd1);
    check_eq("c0_1hot_p1", 32'($countones(if0.wordline[31:16]) <= 1), 32'd1);
    check_eq("c2_1hot_p0", 32'($countones(if2.wordline[11:0])  <= 1), 32'd1);
    check_eq("c2_1hot_p1", 32'($countones(if2.wordline[23:12]) <= 1), 32'd1);
  endtask

  // Advance the model on the current inputs, clock once, then compare.
  task automatic step();
    logic [31:0] wl;
    logic [1:0]  v, b, o;
    int          id;
    for (int c = 0; c < 3; c++) begin
      wl = 32'd0; v = 2'b00; b = 2'b00; o = 2'b00;
      for (int p = 0; p < 2; p++) begin
        id = int'(rd_id[p*4 +: 4]);
        if (rd_valid[p]) begin
          v[p] = 1'b1;
          if (id >= cfg_nr[c]) o[p] = 1'b1;
          else if (!(cfg_zr[c] != 0 && id == 0)) begin
            wl   = wl | (32'd1 << (p * cfg_nr[c] + id));
            b[p] = wr_en && (int'(wr_id) == id);
          end
        end
      end
      if (!rst_n) begin
        m_wl[c] = 32'd0; m_val[c] = 2'b00; m_byp[c] = 2'b00; m_oob[c] = 2'b00; m_sticky[c] = 1'b0;
      end else if (!stall) begin
        m_wl[c] = wl; m_val[c] = v; m_byp[c] = b; m_oob[c] = o;
        m_sticky[c] = m_sticky[c] | (|o);
      end
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    for (int c = 0; c < 3; c++) m_sticky[c] = 1'b0;
    rst_n = 1'b0; stall = 1'b0; rd_valid = 2'b00; rd_id = 8'h00; wr_en = 1'b0; wr_id = 4'h0;
    step();
    step();
    check_eq("rst_wl", if0.wordline, 32'h0000_0000);

    rst_n = 1'b1;
    rd_valid = 2'b11; rd_id = {4'd15, 4'd5}; wr_en = 1'b0;
    step();
    check_eq("tp1_wl",  if0.wordline, 32'h8000_0020);
    check_eq("tp1_val", 32'(if0.wl_valid), 32'd3);
    check_eq("tp1_byp", 32'(if0.bypass), 32'd0);

    rd_id = {4'd4, 4'd3}; wr_en = 1'b1; wr_id = 4'd3;
    step();
    check_eq("tp2_byp", 32'(if0.bypass), 32'd1);
    wr_en = 1'b0;
    step();
    check_eq("tp2_nobyp", 32'(if0.bypass), 32'd0);

    rd_valid = 2'b01; rd_id = 8'h00; wr_en = 1'b1; wr_id = 4'd0;
    step();
    check_eq("tp3_z_wl",   if0.wordline, 32'h0000_0000);
    check_eq("tp3_z_byp",  32'(if0.bypass), 32'd0);
    check_eq("tp3_nz_wl",  if1.wordline, 32'h0000_0001);
    check_eq("tp3_nz_byp", 32'(if1.bypass), 32'd1);

    rst_n = 1'b0; step(); rst_n = 1'b1;
    rd_valid = 2'b01; rd_id = {4'd0, 4'd13}; wr_en = 1'b0;
    step();
    check_eq("tp4_oob", 32'(if2.oob), 32'd1);
    check_eq("tp4_stk", 32'(if2.oob_sticky), 32'd1);
    check_eq("tp4_wl",  32'(if2.wordline), 32'd0);
    rd_id = {4'd0, 4'd2};
    step();
    check_eq("tp4_stk_hold", 32'(if2.oob_sticky), 32'd1);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check_eq("tp4_stk_clr", 32'(if2.oob_sticky), 32'd0);

    rd_valid = 2'b01; rd_id = {4'd0, 4'd7};
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_id = {4'd0, 4'(i + 9)};
      step();
      check_eq("tp5_stall_wl", if0.wordline, 32'h0000_0080);
    end
    stall = 1'b0; rd_id = {4'd0, 4'd10};
    step();
    check_eq("tp5_release", if0.wordline, 32'h0000_0400);

    stall = 1'b1; rd_valid = 2'b11; rd_id = {4'd6, 4'd13}; rst_n = 1'b0;
    step();
    check_eq("tp6_rst_stall", if0.wordline | 32'(if0.wl_valid) | 32'(if2.oob_sticky), 32'd0);
    rst_n = 1'b1; stall = 1'b0;

    for (int i = 0; i < 400; i++) begin
      rst_n    = ($urandom_range(0, 49) != 0);
      stall    = ($urandom_range(0, 4) == 0);
      rd_valid = 2'($urandom);
      rd_id    = 8'($urandom);
      wr_en    = 1'($urandom);
      wr_id    = ($urandom_range(0, 1) == 0) ? rd_id[3:0] : 4'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
